usb_reg_bridge: RTL and testbench



---
 rtl/usb_regmap_pkg.sv | 31 +++
 rtl/usb_strobe_sync.sv | 37 +++
 rtl/usb_reg_bridge.sv | 267 ++++++++++++++++++++++++++
 tb/tb_usb_reg_bridge.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_regmap_pkg.sv
// Register map, picorv32 control-state encodings and STATUS bit positions
// shared by the USB host-bus bridge.
package usb_regmap_pkg;

    localparam logic [15:0] REG_STATUS    = 16'h0000;
    localparam logic [15:0] REG_STATE     = 16'h0010;
    localparam logic [15:0] REG_RX_BASE   = 16'h0020;
    localparam logic [15:0] REG_RX_STRIDE = 16'h0010;

    typedef enum logic [2:0] {
        ST_RUN   = 3'b001,
        ST_LOAD  = 3'b010,
        ST_RESET = 3'b100
    } ctrl_state_e;

    localparam int STAT_MEM_READY = 0;
    localparam int STAT_MEM_OVF   = 1;
    localparam int STAT_RX_UNF    = 2;
    localparam int STAT_PARTIAL   = 3;
    localparam int STAT_RX_EMPTY  = 4;

    // Only the three one-hot encodings are legal; anything else parks the core in reset.
    function automatic ctrl_state_e decode_state(input logic [2:0] value);
        case (value)
            3'b001:  return ST_RUN;
            3'b010:  return ST_LOAD;
            default: return ST_RESET;
        endcase
    endfunction

endpackage

// File: rtl/usb_strobe_sync.sv
// Two-flop synchroniser for an active-low host strobe, plus a one-cycle
// pulse on its synchronised falling edge. All flops idle high.
module usb_strobe_sync (
    input  logic clk_usb,
    input  logic reset,
    input  logic strobe_n,
    output logic sync_n,
    output logic fall
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = strobe_n;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_usb or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sync_n = sync_q;
    assign fall   = prev_q & ~sync_q;

endmodule

// File: rtl/usb_reg_bridge.sv
// Host-bus bridge: decodes the USB parallel-bus register map, packs byte
// writes into memory words and serves the receive FIFOs via snapshot registers.
module usb_reg_bridge
    import usb_regmap_pkg::*;
#(
    parameter int                ADDR_W     = 21,
    parameter int                WORD_BYTES = 4,
    parameter int                NUM_RX     = 2,
    parameter logic [ADDR_W-1:0] MEM_BASE   = 'h0100,
    parameter logic [ADDR_W-1:0] MEM_SIZE   = 'h4000,
    parameter int                RDDLY_LEN  = 3
) (
    input  logic                           clk_usb,
    input  logic                           reset,
    input  logic [ADDR_W-1:0]              addr,
    input  logic [7:0]                     data_in,
    output logic [7:0]                     data_out,
    output logic                           data_oe,
    input  logic                           rd_n,
    input  logic                           wr_n,
    output logic                           mem_wr_valid,
    input  logic                           mem_wr_ready,
    output logic [8*WORD_BYTES-1:0]        mem_wr_data,
    output logic [WORD_BYTES-1:0]          mem_wr_be,
    output logic [ADDR_W-1:0]              mem_wr_addr,
    output logic [2:0]                     ctrl_state,
    output logic                           ctrl_state_stb,
    input  logic [NUM_RX*8*WORD_BYTES-1:0] rx_data,
    input  logic [NUM_RX-1:0]              rx_empty,
    output logic [NUM_RX-1:0]              rx_rd_en
);

    localparam int W      = 8 * WORD_BYTES;
    localparam int LANE_W = $clog2(WORD_BYTES);
    localparam int CNT_W  = $clog2(RDDLY_LEN + 2);

    localparam logic [ADDR_W:0]   WIN_END = {1'b0, MEM_BASE} + {1'b0, MEM_SIZE};
    localparam logic [ADDR_W-1:0] RX_SPAN = ADDR_W'(NUM_RX * REG_RX_STRIDE);

    logic rd_sync_n, rd_ev, wr_sync_n, wr_ev;

    usb_strobe_sync u_rd_sync (
        .clk_usb  (clk_usb),
        .reset    (reset),
        .strobe_n (rd_n),
        .sync_n   (rd_sync_n),
        .fall     (rd_ev)
    );

    usb_strobe_sync u_wr_sync (
        .clk_usb  (clk_usb),
        .reset    (reset),
        .strobe_n (wr_n),
        .sync_n   (wr_sync_n),
        .fall     (wr_ev)
    );

    // Address decode
    logic [ADDR_W-1:0] mem_off, mem_widx, rx_off;
    logic [3:0]        mem_lane, rx_b;
    logic [1:0]        rx_k;
    logic              in_win, is_status, is_state, is_rx;

    assign mem_off   = addr - MEM_BASE;
    assign mem_widx  = mem_off >> LANE_W;
    assign mem_lane  = 4'(mem_off & ADDR_W'(WORD_BYTES - 1));
    assign in_win    = (addr >= MEM_BASE) && ({1'b0, addr} < WIN_END);
    assign rx_off    = addr - ADDR_W'(REG_RX_BASE);
    assign rx_k      = rx_off[5:4];
    assign rx_b      = rx_off[3:0];
    assign is_status = (addr == ADDR_W'(REG_STATUS));
    assign is_state  = (addr == ADDR_W'(REG_STATE));
    assign is_rx     = (addr >= ADDR_W'(REG_RX_BASE)) && (rx_off < RX_SPAN)
                       && (rx_b < 4'(WORD_BYTES));

    // State
    logic [7:0]             data_out_q, data_out_d;
    logic                   oe_q, oe_d;
    logic [CNT_W-1:0]       oe_cnt_q, oe_cnt_d;
    ctrl_state_e            ctrl_state_q, ctrl_state_d;
    logic                   stb_q, stb_d;
    logic [NUM_RX-1:0][W-1:0] hold_q, hold_d;
    logic [NUM_RX-1:0]      rx_rd_en_q, rx_rd_en_d;
    logic                   mem_ovf_q, mem_ovf_d;
    logic                   rx_unf_q, rx_unf_d;
    logic [W-1:0]           word_q, word_d;
    logic [WORD_BYTES-1:0]  be_q, be_d;
    logic [ADDR_W-1:0]      widx_q, widx_d;
    logic                   valid_q, valid_d;
    logic [W-1:0]           out_data_q, out_data_d;
    logic [WORD_BYTES-1:0]  out_be_q, out_be_d;
    logic [ADDR_W-1:0]      out_addr_q, out_addr_d;

    logic                   rd_do, host_rx0;
    logic [7:0]             rd_val, status;
    logic [W-1:0]           word_new;
    logic [WORD_BYTES-1:0]  be_new;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        data_out_d   = data_out_q;
        oe_d         = oe_q;
        oe_cnt_d     = oe_cnt_q;
        ctrl_state_d = ctrl_state_q;
        stb_d        = 1'b0;
        hold_d       = hold_q;
        rx_rd_en_d   = '0;
        mem_ovf_d    = mem_ovf_q;
        rx_unf_d     = rx_unf_q;
        word_d       = word_q;
        be_d         = be_q;
        widx_d       = widx_q;
        valid_d      = 1'b0;
        out_data_d   = out_data_q;
        out_be_d     = out_be_q;
        out_addr_d   = out_addr_q;
        rd_do        = rd_ev & ~wr_ev;
        host_rx0     = 1'b0;
        rd_val       = '0;
        word_new     = word_q;
        be_new       = be_q;

        status                 = '0;
        status[STAT_MEM_READY] = mem_wr_ready;
        status[STAT_MEM_OVF]   = mem_ovf_q;
        status[STAT_RX_UNF]    = rx_unf_q;
        status[STAT_PARTIAL]   = |be_q;
        for (int k = 0; k < NUM_RX; k++) status[STAT_RX_EMPTY + k] = rx_empty[k];

        if (wr_ev) begin
            if (is_status) begin
                if (data_in[STAT_MEM_OVF]) mem_ovf_d = 1'b0;
                if (data_in[STAT_RX_UNF])  rx_unf_d  = 1'b0;
            end else if (is_state) begin
                ctrl_state_d = decode_state(data_in[2:0]);
                stb_d        = 1'b1;
            end else if (in_win) begin
                // A lane landing in a different word abandons the partial one.
                if ((be_q != '0) && (mem_widx != widx_q)) begin
                    word_new = '0;
                    be_new   = '0;
                end
                for (int l = 0; l < WORD_BYTES; l++) begin
                    if (mem_lane == 4'(l)) begin
                        word_new[8*l +: 8] = data_in;
                        be_new[l]          = 1'b1;
                    end
                end
                if (mem_lane == 4'(WORD_BYTES - 1)) begin
                    if (mem_wr_ready) begin
                        valid_d    = 1'b1;
                        out_data_d = word_new;
                        out_be_d   = be_new;
                        out_addr_d = mem_widx;
                    end else begin
                        mem_ovf_d = 1'b1;
                    end
                    word_d = '0;
                    be_d   = '0;
                end else begin
                    word_d = word_new;
                    be_d   = be_new;
                end
                widx_d = mem_widx;
            end
        end

        if (rd_do) begin
            if (is_status) begin
                rd_val = status;
            end else if (is_state) begin
                rd_val = {5'b0, ctrl_state_q};
            end else if (is_rx) begin
                for (int k = 0; k < NUM_RX; k++) begin
                    if (rx_k == 2'(k)) begin
                        if (rx_b == 4'd0) begin
                            if (k == 0) host_rx0 = 1'b1;
                            // A pop still in flight means hold already mirrors the head.
                            if (rx_rd_en_q[k] || rx_empty[k]) begin
                                rd_val = hold_q[k][7:0];
                                if (!rx_rd_en_q[k]) rx_unf_d = 1'b1;
                            end else begin
                                hold_d[k]     = rx_data[k*W +: W];
                                rx_rd_en_d[k] = 1'b1;
                                rd_val        = rx_data[k*W +: 8];
                            end
                        end else begin
                            for (int b = 1; b < WORD_BYTES; b++) begin
                                if (rx_b == 4'(b)) rd_val = hold_q[k][8*b +: 8];
                            end
                        end
                    end
                end
            end
            data_out_d = rd_val;
        end

        if ((ctrl_state_q == ST_LOAD) && !rx_empty[0] && !rx_rd_en_q[0] && !host_rx0) begin
            hold_d[0]     = rx_data[0 +: W];
            rx_rd_en_d[0] = 1'b1;
        end

        if (rd_do) begin
            oe_d     = 1'b1;
            oe_cnt_d = CNT_W'(RDDLY_LEN);
        end else if (oe_q) begin
            if (!rd_sync_n) begin
                oe_cnt_d = CNT_W'(RDDLY_LEN);
            end else if (oe_cnt_q <= CNT_W'(1)) begin
                oe_d     = 1'b0;
                oe_cnt_d = '0;
            end else begin
                oe_cnt_d = oe_cnt_q - CNT_W'(1);
            end
        end
    end

    // NOTE: the hold snapshots and word buffer are plain flops, so they reset like any other state.
    always_ff @(posedge clk_usb or posedge reset) begin
        if (reset) begin
            data_out_q   <= '0;
            oe_q         <= 1'b0;
            oe_cnt_q     <= '0;
            ctrl_state_q <= ST_RESET;
            stb_q        <= 1'b0;
            hold_q       <= '0;
            rx_rd_en_q   <= '0;
            mem_ovf_q    <= 1'b0;
            rx_unf_q     <= 1'b0;
            word_q       <= '0;
            be_q         <= '0;
            widx_q       <= '0;
            valid_q      <= 1'b0;
            out_data_q   <= '0;
            out_be_q     <= '0;
            out_addr_q   <= '0;
        end else begin
            data_out_q   <= data_out_d;
            oe_q         <= oe_d;
            oe_cnt_q     <= oe_cnt_d;
            ctrl_state_q <= ctrl_state_d;
            stb_q        <= stb_d;
            hold_q       <= hold_d;
            rx_rd_en_q   <= rx_rd_en_d;
            mem_ovf_q    <= mem_ovf_d;
            rx_unf_q     <= rx_unf_d;
            word_q       <= word_d;
            be_q         <= be_d;
            widx_q       <= widx_d;
            valid_q      <= valid_d;
            out_data_q   <= out_data_d;
            out_be_q     <= out_be_d;
            out_addr_q   <= out_addr_d;
        end
    end

    assign data_out       = data_out_q;
    assign data_oe        = oe_q;
    assign ctrl_state     = ctrl_state_q;
    assign ctrl_state_stb = stb_q;
    assign rx_rd_en       = rx_rd_en_q;
    assign mem_wr_valid   = valid_q;
    assign mem_wr_data    = out_data_q;
    assign mem_wr_be      = out_be_q;
    assign mem_wr_addr    = out_addr_q;

endmodule

// File: tb/tb_usb_reg_bridge.sv
// Bench for usb_reg_bridge: host-bus tasks, FWFT receive-FIFO models and a
// scoreboard of expected memory pushes.
module tb_usb_reg_bridge;

    logic        clk_usb = 1'b0;
    logic        reset   = 1'b1;
    logic [20:0] addr    = '0;
    logic [7:0]  data_in = '0;
    logic [7:0]  data_out;
    logic        data_oe;
    logic        rd_n = 1'b1;
    logic        wr_n = 1'b1;
    logic        mem_wr_valid;
    logic        mem_wr_ready = 1'b1;
    logic [31:0] mem_wr_data;
    logic [3:0]  mem_wr_be;
    logic [20:0] mem_wr_addr;
    logic [2:0]  ctrl_state;
    logic        ctrl_state_stb;
    logic [63:0] rx_data  = '0;
    logic [1:0]  rx_empty = 2'b11;
    logic [1:0]  rx_rd_en;

    usb_reg_bridge dut (
        .clk_usb        (clk_usb),
        .reset          (reset),
        .addr           (addr),
        .data_in        (data_in),
        .data_out       (data_out),
        .data_oe        (data_oe),
        .rd_n           (rd_n),
        .wr_n           (wr_n),
        .mem_wr_valid   (mem_wr_valid),
        .mem_wr_ready   (mem_wr_ready),
        .mem_wr_data    (mem_wr_data),
        .mem_wr_be      (mem_wr_be),
        .mem_wr_addr    (mem_wr_addr),
        .ctrl_state     (ctrl_state),
        .ctrl_state_stb (ctrl_state_stb),
        .rx_data        (rx_data),
        .rx_empty       (rx_empty),
        .rx_rd_en       (rx_rd_en)
    );

    always #5 clk_usb = ~clk_usb;

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] data;
        logic [3:0]  be;
        logic [20:0] waddr;
    } push_t;

    push_t       sb[$];
    logic [31:0] rx_q[2][$];
    int          pop_cnt[2] = '{0, 0};
    int          stb_cnt = 0;

    // Receive FIFO models: a pop seen during a cycle advances the head after the next edge.
    initial begin
        logic popped[2];
        forever begin
            @(negedge clk_usb);
            for (int k = 0; k < 2; k++) begin
                popped[k] = rx_rd_en[k];
                if (popped[k]) pop_cnt[k]++;
            end
            @(posedge clk_usb);
            #1;
            for (int k = 0; k < 2; k++) begin
                if (popped[k] && rx_q[k].size() > 0) void'(rx_q[k].pop_front());
                rx_empty[k]        = (rx_q[k].size() == 0);
                rx_data[k*32 +: 32] = (rx_q[k].size() > 0) ? rx_q[k][0] : 32'h0;
            end
        end
    end

    always @(negedge clk_usb) begin
        if (!reset && ctrl_state_stb) stb_cnt++;
        if (!reset && mem_wr_valid) begin
            if (sb.size() == 0) begin
                check("push_unexpected", 1, 0);
            end else begin
                push_t e;
                e = sb.pop_front();
                check("push_data", mem_wr_data, e.data);
                check("push_be", mem_wr_be, e.be);
                check("push_addr", mem_wr_addr, e.waddr);
            end
        end
    end

    task automatic host_write(input logic [20:0] a, input logic [7:0] d);
        @(negedge clk_usb);
        addr    = a;
        data_in = d;
        wr_n    = 1'b0;
        repeat (6) @(negedge clk_usb);
        wr_n = 1'b1;
        repeat (4) @(negedge clk_usb);
    endtask

    task automatic host_read(input string tag, input logic [20:0] a, input logic [7:0] exp);
        @(negedge clk_usb);
        addr = a;
        rd_n = 1'b0;
        repeat (6) @(negedge clk_usb);
        check({tag, "_data"}, data_out, exp);
        check({tag, "_oe_on"}, data_oe, 1'b1);
        rd_n = 1'b1;
        repeat (9) @(negedge clk_usb);
        check({tag, "_oe_off"}, data_oe, 1'b0);
    endtask

    task automatic push_exp(input logic [31:0] d, input logic [3:0] be, input logic [20:0] wa);
        push_t e;
        e.data  = d;
        e.be    = be;
        e.waddr = wa;
        sb.push_back(e);
    endtask

    initial begin
        int stb_before, pops_before;

        repeat (3) @(negedge clk_usb);
        reset = 1'b0;
        repeat (3) @(negedge clk_usb);

        check("rst_ctrl_state", ctrl_state, 3'b100);
        check("rst_data_oe", data_oe, 1'b0);
        check("rst_data_out", data_out, 8'h00);
        check("rst_valid", mem_wr_valid, 1'b0);
        check("rst_rd_en", rx_rd_en, 2'b00);
        check("rst_stb", ctrl_state_stb, 1'b0);

        // Full word at the window base
        push_exp(32'h44332211, 4'b1111, 21'd0);
        host_write(21'h0100, 8'h11);
        host_write(21'h0101, 8'h22);
        host_write(21'h0102, 8'h33);
        host_write(21'h0103, 8'h44);
        check("t1_sb_empty", sb.size(), 0);

        // Word restarted at a new index, completed while not ready
        host_write(21'h0104, 8'h55);
        mem_wr_ready = 1'b0;
        host_write(21'h010B, 8'h66);
        host_read("t2_status_ovf", 21'h0000, 8'h32);
        mem_wr_ready = 1'b1;
        host_write(21'h0000, 8'h02);
        host_read("t2_status_clr", 21'h0000, 8'h31);

        // Window boundaries: just outside on both sides, last word inside
        host_write(21'h00FF, 8'h77);
        host_write(21'h4100, 8'h78);
        host_write(21'h4103, 8'h79);
        push_exp(32'hDDCCBBAA, 4'b1111, 21'h0FFF);
        host_write(21'h40FC, 8'hAA);
        host_write(21'h40FD, 8'hBB);
        host_write(21'h40FE, 8'hCC);
        host_write(21'h40FF, 8'hDD);
        host_read("unmapped", 21'h0050, 8'h00);

        // Channel 1 snapshot read
        rx_q[1].push_back(32'hA1B2C3D4);
        repeat (3) @(negedge clk_usb);
        host_read("t3_b0", 21'h0030, 8'hD4);
        host_read("t3_b1", 21'h0031, 8'hC3);
        host_read("t3_b2", 21'h0032, 8'hB2);
        host_read("t3_b3", 21'h0033, 8'hA1);
        check("t3_pops", pop_cnt[1], 1);

        // Channel 0 read, then underflow read of the now-empty channel
        rx_q[0].push_back(32'h5A6B7C8D);
        repeat (3) @(negedge clk_usb);
        host_read("t4_first", 21'h0020, 8'h8D);
        host_read("t4_empty", 21'h0020, 8'h8D);
        check("t4_pops", pop_cnt[0], 1);
        host_read("t4_status_unf", 21'h0000, 8'h35);
        host_write(21'h0000, 8'h04);
        host_read("t4_status_clr", 21'h0000, 8'h31);

        // Control state writes and LOAD auto-drain
        stb_before = stb_cnt;
        host_write(21'h0010, 8'h07);
        check("t5_illegal_state", ctrl_state, 3'b100);
        check("t5_stb_count", stb_cnt - stb_before, 1);
        host_write(21'h0010, 8'h01);
        check("t5_run", ctrl_state, 3'b001);
        rx_q[0].push_back(32'h01020304);
        rx_q[0].push_back(32'h11121314);
        rx_q[0].push_back(32'h21222324);
        repeat (5) @(negedge clk_usb);
        pops_before = pop_cnt[0];
        check("t5_no_drain_in_run", pops_before, 1);
        host_write(21'h0010, 8'h02);
        check("t5_load", ctrl_state, 3'b010);
        repeat (20) @(negedge clk_usb);
        check("t5_drain_pops", pop_cnt[0] - pops_before, 3);
        check("t5_fifo_empty", rx_q[0].size(), 0);
        host_read("t5_state_rd", 21'h0010, 8'h02);
        host_read("t5_hold_b1", 21'h0021, 8'h23);
        host_read("t5_hold_b3", 21'h0023, 8'h21);

        // Reset in the middle of a half-written word
        host_write(21'h0110, 8'hE0);
        host_write(21'h0111, 8'hE1);
        host_read("t6_partial", 21'h0000, 8'h39);
        #3 reset = 1'b1;
        #2;
        check("t6_rst_state", ctrl_state, 3'b100);
        check("t6_rst_oe", data_oe, 1'b0);
        check("t6_rst_valid", mem_wr_valid, 1'b0);
        check("t6_rst_be", mem_wr_be, 4'b0000);
        check("t6_rst_data_out", data_out, 8'h00);
        repeat (3) @(negedge clk_usb);
        reset = 1'b0;
        repeat (3) @(negedge clk_usb);
        host_read("t6_status", 21'h0000, 8'h31);
        push_exp(32'hF3F20000, 4'b1100, 21'd4);
        host_write(21'h0112, 8'hF2);
        host_write(21'h0113, 8'hF3);

        repeat (10) @(negedge clk_usb);
        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
